// File: rtl/cpu_trace_emitter_pkg.sv
// Shared constants, field ordering and helpers for the CPU trace emitter.
package cpu_trace_pkg;

  localparam int TIME_MAX = 9999;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_ZERO   = 8'h30;

  typedef enum logic [3:0] {
    F_CARET, F_TIME, F_AT, F_PC, F_COLON, F_SEP1, F_KIND,
    F_ID, F_SEP2, F_LT, F_EQ, F_SEP3, F_DATA, F_HASH
  } field_e;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_EMIT, ST_TAIL} state_e;

  // Lowercase only: 10..15 map onto 'a'..'f' (8'h57 + 10 = 'a').
  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (CH_ZERO + {4'h0, d}) : (8'h57 + {4'h0, d});
  endfunction

endpackage

// File: rtl/cpu_trace_emitter_if.sv
// Record request / character stream bundle for the trace emitter.
interface cpu_trace_emitter_if #(
  parameter int TIME_W = 14,
  parameter int GRF_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              is_mem;
  logic [TIME_W-1:0] time_in;
  logic [31:0]       pc_in;
  logic [GRF_W-1:0]  grf_in;
  logic [31:0]       addr_in;
  logic [31:0]       data_in;
  logic [7:0]        char;
  logic              char_valid;
  logic              done;
  logic              time_sat;

  modport master (
    output req_valid, is_mem, time_in, pc_in, grf_in, addr_in, data_in,
    input  req_ready, char, char_valid, done, time_sat
  );

  modport slave (
    input  req_valid, is_mem, time_in, pc_in, grf_in, addr_in, data_in,
    output req_ready, char, char_valid, done, time_sat
  );
endinterface

// File: rtl/cpu_trace_emitter_bin2bcd.sv
// Sequential double-dabble: one shift per clock, BIN_W clocks after start.
module trace_bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] bin_q;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      bin_q <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_q <= bin;
        bcd   <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        bcd   <= {adj[14:0], bin_q[BIN_W-1]};
        bin_q <= bin_q << 1;
        cnt   <= cnt + 1'b1;
        if (cnt == CNT_W'(BIN_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/cpu_trace_emitter.sv
// Serializes one write-back record into the ASCII trace stream, one char per clock.
// Build option: define TRACE_SPACE_EN to emit single spaces around "$reg"/"*addr" and "<=".
module cpu_trace_emitter
  import cpu_trace_pkg::*;
#(
  parameter int TIME_W = 14,
  parameter int GRF_W  = 5
) (
  input logic clk,
  input logic reset,
  cpu_trace_emitter_if.slave bus
);

  state_e           state;
  field_e           field;
  logic [2:0]       cnt;
  logic             mem_q;
  logic [GRF_W-1:0] grf_q;
  logic [31:0]      pc_q, addr_q, data_q;

  logic              accept, time_over;
  logic [TIME_W-1:0] time_clip;
  logic              bcd_busy, bcd_done;
  logic [15:0]       bcd;

  assign accept    = bus.req_valid && bus.req_ready;
  assign time_over = 32'(bus.time_in) > 32'(TIME_MAX);
  assign time_clip = time_over ? TIME_W'(TIME_MAX) : bus.time_in;

  trace_bin2bcd_seq #(.BIN_W(TIME_W)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .bin   (time_clip),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // Separator fields simply vanish from the walk when spaces are disabled.
  function automatic field_e next_field(input field_e f);
    field_e n;
    n = field_e'(f + 4'd1);
`ifdef TRACE_SPACE_EN
`else
    if (n == F_SEP1 || n == F_SEP2 || n == F_SEP3) n = field_e'(n + 4'd1);
`endif
    return n;
  endfunction

  logic [2:0] ndig, hpos;
  logic [1:0] tpos, tens;
  logic [3:0] ones, tdig;
  logic [7:0] cur_char;
  logic       last;

  always_comb begin
    if (bcd[15:12] != 4'd0)     ndig = 3'd4;
    else if (bcd[11:8] != 4'd0) ndig = 3'd3;
    else if (bcd[7:4] != 4'd0)  ndig = 3'd2;
    else                        ndig = 3'd1;
    if (int'(grf_q) >= 30)      tens = 2'd3;
    else if (int'(grf_q) >= 20) tens = 2'd2;
    else if (int'(grf_q) >= 10) tens = 2'd1;
    else                        tens = 2'd0;
    ones     = 4'(int'(grf_q) - 10 * int'(tens));
    tpos     = 2'(ndig - 3'd1 - cnt);
    hpos     = 3'd7 - cnt;
    tdig     = bcd[{tpos, 2'b00} +: 4];
    cur_char = 8'h00;
    last     = 1'b1;
    case (field)
      F_CARET: cur_char = CH_CARET;
      F_TIME: begin
        cur_char = CH_ZERO + {4'h0, tdig};
        last     = (cnt == ndig - 3'd1);
      end
      F_AT:    cur_char = CH_AT;
      F_PC: begin
        cur_char = hex_char(pc_q[{hpos, 2'b00} +: 4]);
        last     = (cnt == 3'd7);
      end
      F_COLON: cur_char = CH_COLON;
      F_SEP1, F_SEP2, F_SEP3: cur_char = CH_SPACE;
      F_KIND:  cur_char = mem_q ? CH_STAR : CH_DOLLAR;
      F_ID: begin
        if (mem_q) begin
          cur_char = hex_char(addr_q[{hpos, 2'b00} +: 4]);
          last     = (cnt == 3'd7);
        end else if (tens != 2'd0 && cnt == 3'd0) begin
          cur_char = CH_ZERO + {6'h0, tens};
          last     = 1'b0;
        end else begin
          cur_char = CH_ZERO + {4'h0, ones};
        end
      end
      F_LT:    cur_char = CH_LT;
      F_EQ:    cur_char = CH_EQ;
      F_DATA: begin
        cur_char = hex_char(data_q[{hpos, 2'b00} +: 4]);
        last     = (cnt == 3'd7);
      end
      F_HASH:  cur_char = CH_HASH;
      default: cur_char = 8'h00;
    endcase
  end

  // TAIL keeps req_ready low through the '#' cycle so ready rises only once the line is closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      field          <= F_CARET;
      cnt            <= '0;
      mem_q          <= 1'b0;
      grf_q          <= '0;
      pc_q           <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      bus.req_ready  <= 1'b1;
      bus.char       <= 8'h00;
      bus.char_valid <= 1'b0;
      bus.done       <= 1'b0;
      bus.time_sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mem_q         <= bus.is_mem;
            grf_q         <= bus.grf_in;
            pc_q          <= bus.pc_in;
            addr_q        <= bus.addr_in;
            data_q        <= bus.data_in;
            bus.time_sat  <= time_over;
            bus.req_ready <= 1'b0;
            state         <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (bcd_done && !bcd_busy) begin
            bus.char       <= CH_CARET;
            bus.char_valid <= 1'b1;
            field          <= F_TIME;
            cnt            <= '0;
            state          <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          bus.char <= cur_char;
          if (field == F_HASH) begin
            bus.done <= 1'b1;
            state    <= ST_TAIL;
          end else if (last) begin
            field <= next_field(field);
            cnt   <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_TAIL: begin
          bus.char       <= 8'h00;
          bus.char_valid <= 1'b0;
          bus.done       <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
